// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush/forwarding/trap control and EX retire stream for a
//           5-stage RV32I pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int RADDR_W     = 5,
    parameter int ORDER_W     = 64,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_data_valid,
    input  logic               ex_valid,
    input  logic [RADDR_W-1:0] ex_rs1,
    input  logic [RADDR_W-1:0] ex_rs2,
    input  logic               ex_ill,
    input  logic               ex_trap_req,
    input  logic               ex_jump,
    input  logic               mem_valid,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_is_load,
    input  logic               mem_req,
    input  logic               d_data_valid,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_rd,
    output logic               stall_front,
    output logic               stall_mem,
    output logic               bubble_mem,
    output logic               flush_ex,
    output logic               if_hold,
    output logic [1:0]         fwd_rs1_sel,
    output logic [1:0]         fwd_rs2_sel,
    output logic               trap,
    output logic               mem_timeout,
    output logic               retire_valid,
    output logic               retire_trap,
    output logic [ORDER_W-1:0] retire_order
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic               mem_wait;
    logic               load_use;
    logic               trap_trig;
    logic               jump_take;
    logic               i_wait;
    logic               timeout_hit;
    logic [ORDER_W-1:0] order;

    // Loads in MEM have no result yet, so only ALU results are forwarded from MEM.
    function automatic logic [1:0] fwd_select(
        input logic [RADDR_W-1:0] rs,
        input logic               m_valid,
        input logic               m_is_load,
        input logic [RADDR_W-1:0] m_rd,
        input logic               w_valid,
        input logic [RADDR_W-1:0] w_rd
    );
        if (rs == '0)
            return FWD_RF;
        else if (m_valid && !m_is_load && (m_rd == rs))
            return FWD_MEM;
        else if (w_valid && (w_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        mem_wait    = mem_valid & mem_req & ~d_data_valid;
        load_use    = ~mem_wait & mem_valid & mem_is_load & (mem_rd != '0) & ex_valid
                    & ((ex_rs1 == mem_rd) | (ex_rs2 == mem_rd));
        stall_front = mem_wait | load_use;
        stall_mem   = mem_wait;
        bubble_mem  = load_use;

        trap_trig   = ex_valid & (ex_ill | ex_trap_req) & ~stall_front & ~trap;
        jump_take   = ex_jump & ex_valid & ~stall_front & ~trap & ~trap_trig;
        i_wait      = ~i_data_valid & ~stall_front & ~trap & ~trap_trig & ~jump_take;

        flush_ex    = trap | trap_trig | jump_take | i_wait;
        if_hold     = trap | trap_trig | i_wait;

        retire_valid = ex_valid & ~stall_front & ~trap;
        retire_trap  = trap_trig;
        retire_order = order;

        fwd_rs1_sel = fwd_select(ex_rs1, mem_valid, mem_is_load, mem_rd, wb_valid, wb_rd);
        fwd_rs2_sel = fwd_select(ex_rs2, mem_valid, mem_is_load, mem_rd, wb_valid, wb_rd);
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            logic [CNT_W-1:0] wait_cnt;

            assign timeout_hit = mem_wait && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (!reset_n)
                    wait_cnt <= '0;
                else if (!mem_wait || timeout_hit)
                    wait_cnt <= '0;
                else
                    wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Trap and timeout flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trap        <= 1'b0;
            mem_timeout <= 1'b0;
            order       <= '0;
        end else begin
            if (trap_trig || timeout_hit)
                trap <= 1'b1;
            if (timeout_hit)
                mem_timeout <= 1'b1;
            order <= order + ORDER_W'(retire_valid);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed self-checking bench for pipe_hazard_ctrl with a
//           behavioural reference model checked every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int RW = 5;
    localparam int OW = 64;
    localparam int TO = 4;

    localparam int EV_NONE = 0;
    localparam int EV_MW   = 1;
    localparam int EV_LU   = 2;
    localparam int EV_TRAPPED = 3;
    localparam int EV_TT   = 4;
    localparam int EV_JMP  = 5;
    localparam int EV_IW   = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_data_valid, ex_valid, ex_ill, ex_trap_req, ex_jump;
    logic [RW-1:0] ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic          mem_valid, mem_is_load, mem_req, d_data_valid, wb_valid;
    logic          stall_front, stall_mem, bubble_mem, flush_ex, if_hold;
    logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
    logic          trap, mem_timeout, retire_valid, retire_trap;
    logic [OW-1:0] retire_order;

    int tests = 0;
    int fails = 0;

    bit            armed = 1'b0;
    bit            m_trap, m_to;
    int            m_run;
    logic [OW-1:0] m_order;

    pipe_hazard_ctrl #(.RADDR_W(RW), .ORDER_W(OW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .i_data_valid(i_data_valid),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_ill(ex_ill),
        .ex_trap_req(ex_trap_req), .ex_jump(ex_jump), .mem_valid(mem_valid),
        .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_req(mem_req),
        .d_data_valid(d_data_valid), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stall_front(stall_front), .stall_mem(stall_mem), .bubble_mem(bubble_mem),
        .flush_ex(flush_ex), .if_hold(if_hold), .fwd_rs1_sel(fwd_rs1_sel),
        .fwd_rs2_sel(fwd_rs2_sel), .trap(trap), .mem_timeout(mem_timeout),
        .retire_valid(retire_valid), .retire_trap(retire_trap), .retire_order(retire_order)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Which single event governs this cycle, in priority order.
    function automatic int classify();
        if (mem_valid && mem_req && !d_data_valid) return EV_MW;
        if (mem_valid && mem_is_load && mem_rd != 0 && ex_valid &&
            (ex_rs1 == mem_rd || ex_rs2 == mem_rd)) return EV_LU;
        if (m_trap) return EV_TRAPPED;
        if (ex_valid && (ex_ill || ex_trap_req)) return EV_TT;
        if (ex_valid && ex_jump) return EV_JMP;
        if (!i_data_valid) return EV_IW;
        return EV_NONE;
    endfunction

    function automatic bit retires(input int ev);
        return ex_valid && ev != EV_MW && ev != EV_LU && ev != EV_TRAPPED;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [RW-1:0] rs);
        if (rs == 0) return 2'd0;
        if (mem_valid && !mem_is_load && mem_rd == rs) return 2'd1;
        if (wb_valid && wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit timeout_now(input int ev, input int run);
        return ev == EV_MW && run + 1 == TO;
    endfunction

    function automatic int next_run(input int ev, input int run);
        if (ev != EV_MW || run + 1 == TO) return 0;
        return run + 1;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_trap  <= 1'b0;
            m_to    <= 1'b0;
            m_run   <= 0;
            m_order <= '0;
            armed   <= 1'b1;
        end else begin
            m_trap  <= m_trap | (classify() == EV_TT) | timeout_now(classify(), m_run);
            m_to    <= m_to | timeout_now(classify(), m_run);
            m_run   <= next_run(classify(), m_run);
            m_order <= m_order + (retires(classify()) ? 64'd1 : 64'd0);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("stall_front", stall_front, (classify() == EV_MW || classify() == EV_LU));
            check("stall_mem", stall_mem, classify() == EV_MW);
            check("bubble_mem", bubble_mem, classify() == EV_LU);
            check("flush_ex", flush_ex, m_trap || classify() == EV_TT ||
                  classify() == EV_JMP || classify() == EV_IW);
            check("if_hold", if_hold, m_trap || classify() == EV_TT || classify() == EV_IW);
            check("fwd_rs1_sel", fwd_rs1_sel, exp_fwd(ex_rs1));
            check("fwd_rs2_sel", fwd_rs2_sel, exp_fwd(ex_rs2));
            check("trap", trap, m_trap);
            check("mem_timeout", mem_timeout, m_to);
            check("retire_valid", retire_valid, retires(classify()));
            check("retire_trap", retire_trap, classify() == EV_TT);
            check("retire_order", retire_order, m_order);
        end
    end

    task automatic idle();
        i_data_valid = 1'b1; ex_valid = 1'b0; ex_rs1 = '0; ex_rs2 = '0;
        ex_ill = 1'b0; ex_trap_req = 1'b0; ex_jump = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_is_load = 1'b0; mem_req = 1'b0;
        d_data_valid = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        adv(); adv();
        tick();
        check("lit_reset_trap", trap, 0);
        check("lit_reset_timeout", mem_timeout, 0);
        check("lit_reset_order", retire_order, 0);
        adv();

        // three plain retires: orders 0,1,2
        reset_n = 1'b1;
        ex_valid = 1'b1; ex_rs1 = 5'd1; ex_rs2 = 5'd2;
        tick(); check("lit_ret0", retire_order, 0); adv();
        tick(); check("lit_ret1", retire_order, 1); adv();
        tick(); check("lit_ret2", retire_order, 2); check("lit_ret2_v", retire_valid, 1); adv();

        // load x5 in MEM, EX reads x5
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_req = 1'b1; mem_rd = 5'd5; ex_rs1 = 5'd5;
        tick();
        check("lit_lu_stall", stall_front, 1);
        check("lit_lu_bubble", bubble_mem, 1);
        check("lit_lu_noret", retire_valid, 0);
        adv();
        mem_valid = 1'b0; mem_is_load = 1'b0; mem_req = 1'b0; mem_rd = '0;
        wb_valid = 1'b1; wb_rd = 5'd5;
        tick();
        check("lit_lu_fwd_wb", fwd_rs1_sel, 2'b10);
        check("lit_lu_release", stall_front, 0);
        check("lit_lu_order", retire_order, 3);
        adv();

        // forwarding priority, no retire
        idle();
        mem_valid = 1'b1; mem_rd = 5'd7; wb_valid = 1'b1; wb_rd = 5'd7; ex_rs2 = 5'd7;
        tick(); check("lit_fwd_mem_wins", fwd_rs2_sel, 2'b01); adv();
        mem_rd = '0; ex_rs2 = '0;
        tick(); check("lit_fwd_x0", fwd_rs2_sel, 2'b00); adv();

        // store waits 3 cycles with a jump in EX that must be ignored
        idle();
        mem_valid = 1'b1; mem_req = 1'b1; d_data_valid = 1'b0;
        ex_valid = 1'b1; ex_jump = 1'b1; ex_rs1 = 5'd1; ex_rs2 = 5'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_mw_stall_front", stall_front, 1);
            check("lit_mw_stall_mem", stall_mem, 1);
            check("lit_mw_noflush", flush_ex, 0);
            check("lit_mw_order", retire_order, 4);
            adv();
        end
        d_data_valid = 1'b1; ex_jump = 1'b0;
        tick(); check("lit_mw_resume", retire_valid, 1); check("lit_mw_resume_st", stall_front, 0); adv();

        // jump together with load-use, then jump acts next cycle
        idle();
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_req = 1'b1; mem_rd = 5'd3;
        ex_valid = 1'b1; ex_rs1 = 5'd3; ex_jump = 1'b1;
        tick(); check("lit_jlu_noflush", flush_ex, 0); check("lit_jlu_stall", stall_front, 1); adv();
        mem_valid = 1'b0; mem_is_load = 1'b0; mem_req = 1'b0; mem_rd = '0;
        wb_valid = 1'b1; wb_rd = 5'd3;
        tick(); check("lit_jmp_flush", flush_ex, 1); check("lit_jmp_order", retire_order, 5); adv();
        idle();
        tick(); check("lit_jmp_once", retire_order, 6); adv();

        // i-mem wait: bubble into EX, EX still retires
        ex_valid = 1'b1; i_data_valid = 1'b0;
        tick(); check("lit_iw_hold", if_hold, 1); check("lit_iw_flush", flush_ex, 1);
        check("lit_iw_ret", retire_valid, 1); adv();
        i_data_valid = 1'b1;
        adv(); adv();

        // illegal instruction at order 9
        ex_ill = 1'b1;
        tick();
        check("lit_ill_valid", retire_valid, 1);
        check("lit_ill_trap", retire_trap, 1);
        check("lit_ill_order", retire_order, 9);
        check("lit_ill_pre", trap, 0);
        adv();
        ex_ill = 1'b0; ex_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_trap_sticky", trap, 1);
            check("lit_trap_flush", flush_ex & if_hold, 1);
            check("lit_trap_noret", retire_valid, 0);
            adv();
        end

        // reset in the middle of a d-mem wait, then timeout
        idle();
        mem_valid = 1'b1; mem_req = 1'b1; d_data_valid = 1'b0;
        adv(); adv();
        reset_n = 1'b0;
        adv();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); check("lit_to_pending", trap, 0); adv();
        end
        tick(); check("lit_to_trap", trap, 1); check("lit_to_flag", mem_timeout, 1); adv();
        d_data_valid = 1'b1; ex_valid = 1'b1;
        tick(); check("lit_to_noret", retire_valid, 0); adv();
        adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
